// File: rtl/mm_host_master_if.sv
// Memory-mapped bus between mm_host_master and the QoS register bank.
// Strobes are single-cycle; mm_rdata is valid READ_LATENCY cycles after a read strobe.
interface mm_host_master_if;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;

    modport master (
        output mm_write_en,
        output mm_read_en,
        output mm_addr,
        output mm_wdata,
        input  mm_rdata
    );

    modport slave (
        input  mm_write_en,
        input  mm_read_en,
        input  mm_addr,
        input  mm_wdata,
        output mm_rdata
    );
endinterface

// File: rtl/mm_host_master.sv
// Bus initiator for the QoS register bank: forwards host config writes and host
// reads, and periodically polls status words 0x01 and 0x02.
//
// Host handshake: a requester raises *_req with its address/data and holds them
// stable until the matching *_ack pulse. It drops the request in the cycle after
// the ack; a request that is still high after that is treated as a new one. The
// cycle that carries rd_ack is therefore not a new read request.
module mm_host_master #(
    parameter int POLL_PERIOD  = 50000,
    parameter int READ_LATENCY = 1,
    parameter int TIMER_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_wr_req,
    input  logic [31:0]             cfg_wr_data,
    output logic                    cfg_wr_ack,
    input  logic                    rd_req,
    input  logic [7:0]              rd_addr,
    output logic                    rd_ack,
    output logic [31:0]             rd_data,
    input  logic                    poll_enable,
    mm_host_master_if.master        mm,
    output logic [1:0]              active_channel,
    output logic [3:0]              signal_present,
    output logic [31:0]             error_counts,
    output logic                    status_valid,
    output logic [3:0]              signal_lost,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        RD_ISSUE   = 3'd2,
        RD_WAIT    = 3'd3,
        RD_CAPTURE = 3'd4
    } state_t;

    // Who owns the read currently in flight.
    typedef enum logic [1:0] {
        SRC_HOST  = 2'd0,
        SRC_POLL1 = 2'd1,
        SRC_POLL2 = 2'd2
    } src_t;

    localparam int               WAIT_LAST_I = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [1:0]       WAIT_LAST   = WAIT_LAST_I[1:0];
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [1:0]         wait_q, wait_d;
    logic [7:0]         addr_d;
    logic [31:0]        wdata_d;
    logic [TIMER_W-1:0] timer_q;
    logic               poll_pending_q;
    logic               poll_step2_q;
    logic               start_poll1;
    logic               start_poll2;

    assign mm.mm_write_en = (state_q == WRITE);
    assign mm.mm_read_en  = (state_q == RD_ISSUE);
    assign cfg_wr_ack     = (state_q == WRITE);
    assign dbg_state      = state_q;

    // Next-state, arbitration and the bus address/data to latch on entry to a strobe state.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        wait_d      = wait_q;
        addr_d      = mm.mm_addr;
        wdata_d     = mm.mm_wdata;
        start_poll1 = 1'b0;
        start_poll2 = 1'b0;
        case (state_q)
            IDLE: begin
                // Poll step 2 beats everything so a poll sequence is never split.
                if (poll_step2_q) begin
                    state_d     = RD_ISSUE;
                    src_d       = SRC_POLL2;
                    addr_d      = 8'h02;
                    start_poll2 = 1'b1;
                end else if (cfg_wr_req) begin
                    state_d = WRITE;
                    addr_d  = 8'h00;
                    wdata_d = cfg_wr_data;
                end else if (rd_req && !rd_ack) begin
                    state_d = RD_ISSUE;
                    src_d   = SRC_HOST;
                    addr_d  = rd_addr;
                end else if (poll_pending_q && poll_enable) begin
                    state_d     = RD_ISSUE;
                    src_d       = SRC_POLL1;
                    addr_d      = 8'h01;
                    start_poll1 = 1'b1;
                end
            end
            WRITE:      state_d = IDLE;
            RD_ISSUE: begin
                wait_d  = 2'd0;
                state_d = (READ_LATENCY <= 1) ? RD_CAPTURE : RD_WAIT;
            end
            RD_WAIT: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == WAIT_LAST) begin
                    state_d = RD_CAPTURE;
                end
            end
            RD_CAPTURE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // FSM state, read owner, wait counter and held bus address/data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            src_q       <= SRC_HOST;
            wait_q      <= 2'd0;
            mm.mm_addr  <= 8'h00;
            mm.mm_wdata <= 32'h0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            wait_q      <= wait_d;
            mm.mm_addr  <= addr_d;
            mm.mm_wdata <= wdata_d;
        end
    end

    // Poll timer and sticky pending flag; terminal count wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q        <= '0;
            poll_pending_q <= 1'b0;
        end else if (!poll_enable) begin
            timer_q        <= '0;
            poll_pending_q <= 1'b0;
        end else if (timer_q == TIMER_LAST) begin
            timer_q        <= '0;
            poll_pending_q <= 1'b1;
        end else begin
            timer_q <= timer_q + 1'b1;
            if (start_poll1) begin
                poll_pending_q <= 1'b0;
            end
        end
    end

    // Step 2 of a poll is owed from the capture of 0x01 until 0x02 is issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            poll_step2_q <= 1'b0;
        end else if (state_q == RD_CAPTURE && src_q == SRC_POLL1) begin
            poll_step2_q <= 1'b1;
        end else if (start_poll2) begin
            poll_step2_q <= 1'b0;
        end
    end

    // Capture read data into host result or decoded status; pulses last one cycle.
    // signal_present doubles as the previous-presence record for loss detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ack         <= 1'b0;
            rd_data        <= 32'h0;
            active_channel <= 2'd0;
            signal_present <= 4'd0;
            signal_lost    <= 4'd0;
            error_counts   <= 32'h0;
            status_valid   <= 1'b0;
        end else begin
            rd_ack       <= 1'b0;
            status_valid <= 1'b0;
            signal_lost  <= 4'd0;
            if (state_q == RD_CAPTURE) begin
                case (src_q)
                    SRC_HOST: begin
                        rd_ack  <= 1'b1;
                        rd_data <= mm.mm_rdata;
                    end
                    SRC_POLL1: begin
                        active_channel <= mm.mm_rdata[1:0];
                        signal_present <= mm.mm_rdata[5:2];
                        signal_lost    <= signal_present & ~mm.mm_rdata[5:2];
                    end
                    SRC_POLL2: begin
                        error_counts <= mm.mm_rdata;
                        status_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/mm_host_master.md
Name: mm_host_master

Overview:
- Memory-mapped initiator that drives the QoS register bank's write/read bus on behalf of a host-side command port.
- Forwards host config writes (addr 0x00) and host reads, and autonomously polls status words 0x01 (signal_present/active_channel) and 0x02 (packed error counts) at a fixed period.
- Exposes decoded, registered status plus a signal-loss event flag to upstream logic.

Parameters:
- POLL_PERIOD, 50000, clock cycles between automatic poll sequences (≥4).
- READ_LATENCY, 1, cycles from mm_read_en assertion to mm_rdata valid (1..3).
- TIMER_W, 16, width of poll timer; must hold POLL_PERIOD-1.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- cfg_wr_req  input  1  host config write request; held until ack
- cfg_wr_data  input  32  data for register 0x00
- cfg_wr_ack  output  1  one-cycle pulse: write issued on bus
- rd_req  input  1  host read request; held until ack
- rd_addr  input  8  host read address
- rd_ack  output  1  one-cycle pulse: rd_data valid
- rd_data  output  32  host read result
- poll_enable  input  1  enables periodic status polling
- mm_write_en  output  1  bus write strobe
- mm_read_en  output  1  bus read strobe
- mm_addr  output  8  bus address
- mm_wdata  output  32  bus write data
- mm_rdata  input  32  bus read data
- active_channel  output  2  polled 0x01[1:0]
- signal_present  output  4  polled 0x01[5:2]
- error_counts  output  32  polled 0x02 {ch3,ch2,ch1,ch0}
- status_valid  output  1  one-cycle pulse after a complete poll sequence
- signal_lost  output  4  one-cycle pulse; bit i set when signal_present[i] fell 1->0 between successive polls

Behaviour:
- Reset (async, rstn=0): all outputs 0, FSM IDLE, poll timer 0, poll_pending 0, previous-presence register 0. Reset mid-transaction aborts it; no ack is issued.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPTURE.
- Arbitration in IDLE, evaluated every cycle, fixed priority: cfg_wr_req > rd_req > poll_pending. Only one bus transaction in flight; strobes never overlap.
- WRITE (1 cycle): mm_write_en=1, mm_addr=0x00, mm_wdata=cfg_wr_data; cfg_wr_ack=1 same cycle; next IDLE. Requester drops request after ack; a request still high in the following IDLE cycle is a new request.
- RD_ISSUE (1 cycle): mm_read_en=1, mm_addr=target (rd_addr, or 0x01/0x02 for poll). RD_WAIT lasts READ_LATENCY-1 cycles (zero when 1). RD_CAPTURE samples mm_rdata in cycle issue+READ_LATENCY; result registered, visible next cycle.
- Host read: rd_ack=1 and rd_data=sample in cycle issue+READ_LATENCY+1; rd_data holds until next host read.
- mm_addr/mm_wdata hold last driven value outside strobes; strobes low otherwise.
- Poll sequence: read 0x01 then read 0x02 as two back-to-back transactions (FSM returns through IDLE, but poll step 2 outranks new host requests, so sequence is atomic). Once 0x01 captured: active_channel, signal_present update; signal_lost = prev_present & ~new_present for one cycle; prev_present <= new. Once 0x02 captured: error_counts update, status_valid pulses same cycle.
- Poll timer: counts 0..POLL_PERIOD-1 while poll_enable=1, wraps to 0; at terminal count sets poll_pending (sticky; a second expiry while pending does not queue another). poll_pending cleared when step 1 issues. poll_enable=0 holds timer at 0 and clears pending; a sequence already started completes.
- Unmapped host addresses are issued normally; whatever mm_rdata returns is passed through.

Test Plan:
- Reset with all inputs idle -> all outputs 0; release, poll_enable=0 for 100 cycles -> no strobes.
- cfg_wr_req=1, cfg_wr_data=0x000A_50E5 -> next cycle mm_write_en=1, mm_addr=0x00, mm_wdata=0x000A50E5, cfg_wr_ack=1 for exactly one cycle.
- rd_req=1, rd_addr=0x02, slave model returns 0x04030201 with READ_LATENCY=1 -> mm_read_en one cycle, rd_ack two cycles later with rd_data=0x04030201; repeat with READ_LATENCY=3 -> ack 4 cycles after strobe.
- POLL_PERIOD=8, poll_enable=1, slave 0x01=0x3D, 0x02=0x11223344 -> reads 0x01 then 0x02 every 8 cycles; active_channel=1, signal_present=0xF, error_counts=0x11223344, status_valid pulse once per sequence.
- Next poll with 0x01=0x15 (present 0x5) -> signal_lost=0xA for one cycle; following unchanged poll -> signal_lost=0.
- cfg_wr_req, rd_req and poll_pending asserted in same cycle -> order: write, host read, poll; assert rstn low during RD_WAIT -> no rd_ack, outputs 0, FSM restarts from IDLE.
